// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard (device-side) transmitter.
// Bytes are queued in a small FIFO and sent as 11-bit frames:
// start(0), 8 data bits LSB first, odd parity, stop(1).
// The host may inhibit at any time; an aborted frame is resent from a hold
// register before any further queued byte.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 8,   // clk cycles per ps2_clk half-period
  parameter int FIFO_DEPTH = 8,   // power of two
  parameter int GAP_CYCLES = 16   // idle cycles after every frame
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       host_inhibit,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_dat
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BIT_HI  = 3'd1,
    BIT_LO  = 3'd2,
    GAP     = 3'd3,
    INHIBIT = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          overflow_q;
  logic          push, pop, empty;
  logic [7:0]    head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);
  // full blocks the write even when the FSM pops in the same cycle
  assign push  = wr_en & ~full;
  assign head  = mem_q[rptr_q];

  // next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // storage array; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // sticky overflow flag, only reset clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              overflow_q <= 1'b0;
    else if (wr_en && full) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

  // ---------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------
  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [3:0]    bit_q;
  logic [10:0]   shift_q;
  logic [7:0]    hold_q;
  logic          resend_q;
  logic          clk_q, dat_q;

  logic          can_start, start, abort, div_last, gap_done;
  logic [7:0]    next_byte;
  logic [10:0]   frame_d;

  assign div_last  = (div_q == DIV_LAST);
  assign gap_done  = (div_q == GAP_LAST);
  // a pending resend takes priority over the FIFO head
  assign can_start = (~empty | resend_q) & ~host_inhibit;
  // leaving GAP straight into the next frame keeps the idle spacing at
  // exactly GAP_CYCLES between back-to-back frames
  assign start     = can_start &
                     ((state_q == IDLE) || ((state_q == GAP) && gap_done));
  assign pop       = start & ~resend_q;
  assign next_byte = resend_q ? hold_q : head;
  assign frame_d   = {1'b1, ~^next_byte, next_byte, 1'b0};
  // once the stop bit is on the wire the frame counts as delivered
  assign abort     = host_inhibit & (bit_q < 4'd10);

  // single-process FSM; line outputs are registered alongside the state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      resend_q <= 1'b0;
      clk_q    <= 1'b1;
      dat_q    <= 1'b1;
    end else if (start) begin
      state_q  <= BIT_HI;
      shift_q  <= frame_d;
      hold_q   <= next_byte;
      resend_q <= 1'b0;
      bit_q    <= '0;
      div_q    <= '0;
      clk_q    <= 1'b1;
      dat_q    <= frame_d[0];
    end else begin
      case (state_q)
        IDLE: begin
          clk_q <= 1'b1;
          dat_q <= 1'b1;
        end
        BIT_HI: begin
          if (abort) begin
            state_q  <= INHIBIT;
            resend_q <= 1'b1;
            div_q    <= '0;
            clk_q    <= 1'b1;
            dat_q    <= 1'b1;
          end else if (div_last) begin
            state_q <= BIT_LO;
            div_q   <= '0;
            clk_q   <= 1'b0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        BIT_LO: begin
          if (abort) begin
            state_q  <= INHIBIT;
            resend_q <= 1'b1;
            div_q    <= '0;
            clk_q    <= 1'b1;
            dat_q    <= 1'b1;
          end else if (div_last) begin
            div_q   <= '0;
            shift_q <= {1'b0, shift_q[10:1]};
            bit_q   <= bit_q + 1'b1;
            clk_q   <= 1'b1;
            if (bit_q == 4'd10) begin
              state_q <= GAP;
              dat_q   <= 1'b1;
            end else begin
              state_q <= BIT_HI;
              dat_q   <= shift_q[1];
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        GAP: begin
          clk_q <= 1'b1;
          dat_q <= 1'b1;
          // an inhibit at the end of the gap just holds us here
          if (gap_done) begin
            if (!host_inhibit) state_q <= IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        INHIBIT: begin
          clk_q <= 1'b1;
          dat_q <= 1'b1;
          if (!host_inhibit) begin
            state_q <= GAP;
            div_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          clk_q   <= 1'b1;
          dat_q   <= 1'b1;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE) | ~empty;
  assign ps2_clk = clk_q;
  assign ps2_dat = dat_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: directed scenarios followed by randomized bursts with
// random host inhibit pulses. A line-level receiver decodes frames on falling
// ps2_clk edges and the received byte stream is compared with the bytes the
// FIFO is expected to accept.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int GAP_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rstn, wr_en, host_inhibit;
  logic [7:0] wr_data;
  logic       full, busy, overflow, ps2_clk, ps2_dat;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  expq[$];
  int          gapq[$];
  int          falls = 0;
  int          nbits = 0;
  int          high_run = 0;
  logic [10:0] fr = '0;
  logic [10:0] last_frame = '0;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .host_inhibit(host_inhibit), .full(full), .busy(busy), .overflow(overflow),
    .ps2_clk(ps2_clk), .ps2_dat(ps2_dat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // drive one write this cycle; keep=1 means the byte should reach the wire
  task automatic write(input logic [7:0] b, input bit keep);
    wr_en   = 1'b1;
    wr_data = b;
    if (keep) expq.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    ticks(2);
  endtask

  task automatic cmp_queues(input string tag);
    int n;
    chk({tag, "_count"}, rxq.size(), expq.size());
    n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'd0, rxq[i]}, {24'd0, expq[i]});
    rxq.delete();
    expq.delete();
  endtask

  // receiver: sample data on each ps2_clk fall; a long all-high stretch means
  // any partial frame was abandoned
  initial begin
    logic pc, pd;
    pc = 1'b1;
    pd = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        nbits = 0; high_run = 0; pc = 1'b1; pd = 1'b1;
      end else begin
        if (pc === 1'b1 && ps2_clk === 1'b0) begin
          fr[nbits] = ps2_dat;
          nbits++;
          falls++;
          if (nbits == 11) begin
            chk("rx_start", {31'd0, fr[0]}, 32'd0);
            chk("rx_stop", {31'd0, fr[10]}, 32'd1);
            chk("rx_parity", {31'd0, fr[9]}, ($countones(fr[8:1]) % 2 == 0) ? 32'd1 : 32'd0);
            rxq.push_back(fr[8:1]);
            last_frame = fr;
            nbits = 0;
          end
        end
        if (pd === 1'b1 && ps2_dat === 1'b0 && ps2_clk === 1'b1 && nbits == 0)
          gapq.push_back(high_run);
        if (ps2_clk === 1'b1 && ps2_dat === 1'b1) high_run++;
        else high_run = 0;
        if (high_run > CLK_DIV) nbits = 0;
        pc = ps2_clk;
        pd = ps2_dat;
      end
    end
  end

  initial begin
    logic [10:0] exp_1c;
    bit          saw_low;
    int          n, f0, len, sent, inh_left;

    rstn = 1'b0; wr_en = 1'b0; wr_data = '0; host_inhibit = 1'b0;
    ticks(3);
    chk("rst_clk", {31'd0, ps2_clk}, 32'd1);
    chk("rst_dat", {31'd0, ps2_dat}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rstn = 1'b1;
    ticks(20);

    // single byte: latency, bit sequence, frame + gap length
    write(8'h1C, 1);
    chk("t1_dat_n1", {31'd0, ps2_dat}, 32'd1);
    chk("t1_busy_n1", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_dat_n2", {31'd0, ps2_dat}, 32'd0);
    chk("t1_clk_n2", {31'd0, ps2_clk}, 32'd1);
    ticks(CLK_DIV - 1);
    chk("t1_clk_before_fall", {31'd0, ps2_clk}, 32'd1);
    tick();
    chk("t1_clk_fall", {31'd0, ps2_clk}, 32'd0);
    ticks(22 * CLK_DIV + GAP_CYCLES - CLK_DIV - 1);
    chk("t1_busy_last", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    exp_1c = 11'b100_0011_1000;
    chk("t1_bits", {21'd0, last_frame}, {21'd0, exp_1c});
    ticks(2);
    cmp_queues("t1");

    // make/break sequence, gap spacing
    gapq.delete();
    write(8'h1C, 1); write(8'hF0, 1); write(8'h1C, 1);
    wait_idle(2000);
    chk("t2_gaps", gapq.size(), 3);
    if (gapq.size() >= 3) begin
      chk("t2_gap1", gapq[1], GAP_CYCLES);
      chk("t2_gap2", gapq[2], GAP_CYCLES);
    end
    cmp_queues("t2");

    // overflow: first byte popped immediately, next 8 fill the FIFO, 10th lost
    for (int i = 0; i < 10; i++) write(8'h20 + 8'(i), i < FIFO_DEPTH + 1);
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    wait_idle(5000);
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    cmp_queues("t3");

    // inhibit during data bit 4 of 0x5A, then resend before queued bytes
    write(8'h5A, 1); write(8'h33, 1); write(8'h44, 1);
    n = 0;
    while (nbits != 5 && n < 400) begin tick(); n++; end
    chk("t4_sync", nbits, 5);
    ticks(CLK_DIV);
    chk("t4_in_bit_hi", {31'd0, ps2_clk}, 32'd1);
    host_inhibit = 1'b1;
    tick();
    chk("t4_lines_hi", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    saw_low = 1'b0;
    repeat (30) begin
      tick();
      if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) saw_low = 1'b1;
    end
    chk("t4_held_high", {31'd0, saw_low}, 32'd0);
    host_inhibit = 1'b0;
    ticks(GAP_CYCLES);
    chk("t4_gap_end", {31'd0, ps2_dat}, 32'd1);
    tick();
    chk("t4_resend_start", {31'd0, ps2_dat}, 32'd0);
    wait_idle(2000);
    cmp_queues("t4");

    // inhibit held while writing: nothing moves until release
    host_inhibit = 1'b1;
    tick();
    write(8'h12, 1);
    saw_low = 1'b0;
    repeat (40) begin
      tick();
      if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) saw_low = 1'b1;
    end
    chk("t5_no_activity", {31'd0, saw_low}, 32'd0);
    host_inhibit = 1'b0;
    tick();
    chk("t5_start", {31'd0, ps2_dat}, 32'd0);
    wait_idle(1000);
    cmp_queues("t5");

    // reset mid-frame with bytes queued: everything is lost
    for (int i = 0; i < 4; i++) write(8'h40 + 8'(i), 0);
    ticks(60);
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    ticks(3);
    rstn = 1'b1;
    f0 = falls;
    ticks(500);
    chk("t6_no_falls", falls, f0);
    chk("t6_no_frames", rxq.size(), 0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    rxq.delete();
    expq.delete();

    // randomized bursts with random inhibit pulses
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, FIFO_DEPTH);
      sent = 0; inh_left = 0; n = 0;
      while ((sent < len || busy !== 1'b0) && n < 20000) begin
        if (inh_left > 0) begin
          host_inhibit = 1'b1;
          inh_left--;
        end else begin
          host_inhibit = 1'b0;
          if ($urandom_range(0, 99) == 0) inh_left = $urandom_range(1, 20);
        end
        if (sent < len && $urandom_range(0, 3) != 0) begin
          wr_en = 1'b1;
          wr_data = 8'($urandom);
          expq.push_back(wr_data);
          sent++;
        end else begin
          wr_en = 1'b0;
        end
        tick();
        n++;
      end
      wr_en = 1'b0;
      host_inhibit = 1'b0;
      chk("rnd_timeout", {31'd0, n >= 20000}, 32'd0);
      ticks(5);
      cmp_queues("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
